// File: rtl/bitplane_2_raster_if.sv
// Bitplane-to-raster bus: command/memory bytes in, palette-indexed pixel out.
// Latency: not applicable (signal bundle only).
// Backpressure: none; the pixel-clock phase counter paces the stream.
interface bitplane_2_raster_if;
    logic [3:0]  pc_ena_in;
    logic [23:0] bp_2_rast_cmd;
    logic [15:0] cmd_in;
    logic [7:0]  ram_byte;
    logic [7:0]  ram_byte_h;
    logic [7:0]  pixel_out;
    logic [7:0]  pixel_out_h;
    logic        pixel_out_ena;
    logic [3:0]  pc_ena_out;

    modport master (
        output pc_ena_in, bp_2_rast_cmd, cmd_in, ram_byte, ram_byte_h,
        input  pixel_out, pixel_out_h, pixel_out_ena, pc_ena_out
    );

    modport slave (
        input  pc_ena_in, bp_2_rast_cmd, cmd_in, ram_byte, ram_byte_h,
        output pixel_out, pixel_out_h, pixel_out_ena, pc_ena_out
    );
endinterface

// File: rtl/bitplane_2_raster.sv
// Converts packed bitplane/font bytes into one palette index per pixel slot.
// Latency: 2 advance events (pc_ena_in == PIPE_PHASE); pc_ena_out is 1 clk.
// Backpressure: none; pipeline simply holds on edges outside PIPE_PHASE.
module bitplane_2_raster #(
    parameter logic [3:0] PIPE_PHASE    = 4'd0,
    parameter int         TXT_PAL_SHIFT = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    bitplane_2_raster_if.slave bus
);

    logic        advance;

    // Stage 1 holding registers
    logic [23:0] s1_cmd;
    logic [15:0] s1_cmd_in;
    logic [7:0]  s1_byte;
    logic [7:0]  s1_byte_h;

    // Stage 2 output registers
    logic [7:0]  pix_q;
    logic [7:0]  pix_h_q;
    logic        pix_ena_q;
    logic [3:0]  pc_ena_q;

    // Decoded stage-1 fields
    logic [7:0]  fg_col;
    logic [7:0]  bg_col;
    logic [1:0]  ppb;
    logic        wide_pix;
    logic        txt_slave;
    logic        win_ena;
    logic        two_byte_col;
    logic [2:0]  sub_x;

    // Next-state values computed from stage 1
    logic [7:0]  sh_1bpp;
    logic [7:0]  sh_2bpp;
    logic [3:0]  idx4;
    logic [1:0]  idx2;
    logic        bit1;
    logic [3:0]  txt_col;
    logic [7:0]  txt_ext;
    logic [7:0]  txt_pix;
    logic [7:0]  pix_d;
    logic [7:0]  pix_h_d;
    logic        pix_ena_d;

    logic        unused_bits;

    assign advance      = (bus.pc_ena_in == PIPE_PHASE);

    assign fg_col       = s1_cmd[23:16];
    assign bg_col       = s1_cmd[15:8];
    assign ppb          = s1_cmd[1:0];
    assign wide_pix     = s1_cmd[2];
    assign txt_slave    = s1_cmd[6];
    assign win_ena      = s1_cmd_in[7];
    assign two_byte_col = s1_cmd_in[6];
    assign sub_x        = s1_cmd_in[2:0];

    assign unused_bits  = ^{s1_cmd[7], s1_cmd[5:3], s1_cmd_in[5:3]};

    // MSB-first field select: shift the wanted field up to the top of the byte.
    always_comb begin
        sh_1bpp = s1_byte << sub_x;
        sh_2bpp = s1_byte << {sub_x[1:0], 1'b0};
        idx4    = sub_x[0] ? s1_byte[3:0] : s1_byte[7:4];
        idx2    = sh_2bpp[7:6];
        bit1    = sh_1bpp[7];
        txt_col = bit1 ? s1_cmd_in[15:12] : s1_cmd_in[11:8];
        txt_ext = {4'h0, txt_col};
        txt_pix = txt_ext << TXT_PAL_SHIFT;
    end

    always_comb begin
        pix_d     = 8'h00;
        pix_h_d   = 8'h00;
        pix_ena_d = 1'b0;
        if (win_ena) begin
            pix_ena_d = 1'b1;
            unique case (ppb)
                2'd0: pix_d = s1_byte;
                2'd1: pix_d = bg_col + {4'h0, idx4};
                2'd2: pix_d = bg_col + {6'h00, idx2};
                2'd3: begin
                    if (txt_slave) pix_d = txt_pix;
                    else           pix_d = bit1 ? fg_col : bg_col;
                end
                default: pix_d = 8'h00;
            endcase
            if (wide_pix || two_byte_col) pix_h_d = s1_byte_h;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_cmd    <= '0;
            s1_cmd_in <= '0;
            s1_byte   <= '0;
            s1_byte_h <= '0;
            pix_q     <= '0;
            pix_h_q   <= '0;
            pix_ena_q <= 1'b0;
            pc_ena_q  <= '0;
        end else begin
            pc_ena_q <= bus.pc_ena_in;
            if (advance) begin
                s1_cmd    <= bus.bp_2_rast_cmd;
                s1_cmd_in <= bus.cmd_in;
                s1_byte   <= bus.ram_byte;
                s1_byte_h <= bus.ram_byte_h;
                pix_q     <= pix_d;
                pix_h_q   <= pix_h_d;
                pix_ena_q <= pix_ena_d;
            end
        end
    end

    assign bus.pixel_out     = pix_q;
    assign bus.pixel_out_h   = pix_h_q;
    assign bus.pixel_out_ena = pix_ena_q;
    assign bus.pc_ena_out    = pc_ena_q;

endmodule

// File: tb/tb_bitplane_2_raster.sv
// Directed bench for bitplane_2_raster: default instance plus a second one
// with PIPE_PHASE=5 and TXT_PAL_SHIFT=2 sharing the same stimulus.
module tb_bitplane_2_raster;
    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_pass;

    bitplane_2_raster_if bus ();
    bitplane_2_raster_if bus2 ();

    bitplane_2_raster dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    bitplane_2_raster #(.PIPE_PHASE(4'd5), .TXT_PAL_SHIFT(2)) dut2 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2.slave)
    );

    assign bus2.pc_ena_in     = bus.pc_ena_in;
    assign bus2.bp_2_rast_cmd = bus.bp_2_rast_cmd;
    assign bus2.cmd_in        = bus.cmd_in;
    assign bus2.ram_byte      = bus.ram_byte;
    assign bus2.ram_byte_h    = bus.ram_byte_h;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input logic [3:0] ph);
        bus.pc_ena_in = ph;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [23:0] cmd, input logic [15:0] ci,
                          input logic [7:0] b, input logic [7:0] bh);
        bus.bp_2_rast_cmd = cmd;
        bus.cmd_in        = ci;
        bus.ram_byte      = b;
        bus.ram_byte_h    = bh;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        set_in(24'h0F0183, 16'h0080, 8'hFF, 8'hFF);
        tick(4'd0);
        tick(4'd9);
        tick(4'd0);
        n_checks++;
        if ({bus.pixel_out, bus.pixel_out_h, bus.pixel_out_ena} !== 17'h0)
            $display("FAIL reset_out: got %h/%h/%b want 00/00/0",
                     bus.pixel_out, bus.pixel_out_h, bus.pixel_out_ena);
        else n_pass++;
        n_checks++;
        if (bus.pc_ena_out !== 4'd0)
            $display("FAIL reset_pc_ena_out: got %0d want 0", bus.pc_ena_out);
        else n_pass++;
        #3 reset_n = 1'b1;
    endtask

    task automatic test_8bpp;
        set_in(24'h0F0100, 16'h0080, 8'hA5, 8'h00);
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out_ena !== 1'b0 || bus.pixel_out !== 8'h00)
            $display("FAIL 8bpp_first_adv: got %h/%b want 00/0", bus.pixel_out, bus.pixel_out_ena);
        else n_pass++;
        tick(4'd3);
        n_checks++;
        if (bus.pixel_out_ena !== 1'b0)
            $display("FAIL 8bpp_nonphase_hold: got ena %b want 0", bus.pixel_out_ena);
        else n_pass++;
        n_checks++;
        if (bus.pc_ena_out !== 4'd3)
            $display("FAIL pc_ena_out_delay: got %0d want 3", bus.pc_ena_out);
        else n_pass++;
        bus.ram_byte = 8'h11;
        tick(4'd7);
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out !== 8'hA5 || bus.pixel_out_ena !== 1'b1)
            $display("FAIL 8bpp_second_adv: got %h/%b want a5/1", bus.pixel_out, bus.pixel_out_ena);
        else n_pass++;
        bus.ram_byte = 8'h22;
        tick(4'd2);
        tick(4'd6);
        n_checks++;
        if (bus.pixel_out !== 8'hA5 || bus.pixel_out_ena !== 1'b1)
            $display("FAIL 8bpp_hold_out: got %h/%b want a5/1", bus.pixel_out, bus.pixel_out_ena);
        else n_pass++;
    endtask

    task automatic test_1bpp;
        logic [7:0] exp_px [8];
        exp_px = '{8'h0F, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h0F};
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) set_in(24'h0F0103, 16'h0080 | 16'(i), 8'h81, 8'h00);
            tick(4'd0);
            if (i >= 1) begin
                n_checks++;
                if (bus.pixel_out !== exp_px[i-1] || bus.pixel_out_ena !== 1'b1)
                    $display("FAIL 1bpp_x%0d: got %h/%b want %h/1",
                             i-1, bus.pixel_out, bus.pixel_out_ena, exp_px[i-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_4bpp_2bpp;
        logic [7:0] exp_px [6];
        exp_px = '{8'hFB, 8'h04, 8'h13, 8'h12, 8'h11, 8'h10};
        for (int i = 0; i <= 6; i++) begin
            if (i < 2)      set_in(24'h00F801, 16'h0080 | 16'(i), 8'h3C, 8'h00);
            else if (i < 6) set_in(24'h001002, 16'h0080 | 16'(i-2), 8'hE4, 8'h00);
            tick(4'd0);
            if (i >= 1) begin
                n_checks++;
                if (bus.pixel_out !== exp_px[i-1])
                    $display("FAIL nbpp_vec%0d: got %h want %h", i-1, bus.pixel_out, exp_px[i-1]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_text;
        for (int i = 0; i <= 8; i++) begin
            if (i < 8) set_in(24'h334443, 16'hA280 | 16'(i), 8'hF0, 8'h00);
            tick(4'd0);
            if (i >= 1) begin
                n_checks++;
                if (bus.pixel_out !== ((i-1) < 4 ? 8'h0A : 8'h02))
                    $display("FAIL text_x%0d: got %h want %h", i-1, bus.pixel_out,
                             ((i-1) < 4 ? 8'h0A : 8'h02));
                else n_pass++;
            end
        end
        set_in(24'h334443, 16'hA280, 8'hF0, 8'h00);
        tick(4'd5);
        set_in(24'h334443, 16'hA284, 8'hF0, 8'h00);
        tick(4'd5);
        n_checks++;
        if (bus2.pixel_out !== 8'h28)
            $display("FAIL text_shift_fg: got %h want 28", bus2.pixel_out);
        else n_pass++;
        tick(4'd5);
        n_checks++;
        if (bus2.pixel_out !== 8'h08)
            $display("FAIL text_shift_bg: got %h want 08", bus2.pixel_out);
        else n_pass++;
    endtask

    task automatic test_window_hi;
        set_in(24'h000000, 16'h0080, 8'hFF, 8'h00);
        tick(4'd0);
        set_in(24'h000000, 16'h0000, 8'hFF, 8'h00);
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out !== 8'hFF || bus.pixel_out_ena !== 1'b1)
            $display("FAIL win_on: got %h/%b want ff/1", bus.pixel_out, bus.pixel_out_ena);
        else n_pass++;
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out !== 8'h00 || bus.pixel_out_ena !== 1'b0 || bus.pixel_out_h !== 8'h00)
            $display("FAIL win_off: got %h/%h/%b want 00/00/0",
                     bus.pixel_out, bus.pixel_out_h, bus.pixel_out_ena);
        else n_pass++;
        set_in(24'h000004, 16'h0080, 8'h12, 8'h7E);
        tick(4'd0);
        set_in(24'h000000, 16'h00C0, 8'h34, 8'h7E);
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out_h !== 8'h7E || bus.pixel_out !== 8'h12)
            $display("FAIL hi_mode16: got %h/%h want 12/7e", bus.pixel_out, bus.pixel_out_h);
        else n_pass++;
        set_in(24'h000000, 16'h0080, 8'h56, 8'h7E);
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out_h !== 8'h7E)
            $display("FAIL hi_two_byte: got %h want 7e", bus.pixel_out_h);
        else n_pass++;
        set_in(24'h000004, 16'h0000, 8'h56, 8'h7E);
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out_h !== 8'h00 || bus.pixel_out !== 8'h56)
            $display("FAIL hi_plain: got %h/%h want 56/00", bus.pixel_out, bus.pixel_out_h);
        else n_pass++;
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out_h !== 8'h00 || bus.pixel_out_ena !== 1'b0)
            $display("FAIL hi_win_off: got %h/%b want 00/0", bus.pixel_out_h, bus.pixel_out_ena);
        else n_pass++;
    endtask

    task automatic test_reset_mid;
        set_in(24'h000004, 16'h0080, 8'hA5, 8'h7E);
        tick(4'd0);
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out !== 8'hA5 || bus.pixel_out_ena !== 1'b1)
            $display("FAIL mid_pre: got %h/%b want a5/1", bus.pixel_out, bus.pixel_out_ena);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({bus.pixel_out, bus.pixel_out_h, bus.pixel_out_ena, bus.pc_ena_out} !== 21'h0)
            $display("FAIL mid_async: got %h/%h/%b/%0d want 00/00/0/0",
                     bus.pixel_out, bus.pixel_out_h, bus.pixel_out_ena, bus.pc_ena_out);
        else n_pass++;
        #2 reset_n = 1'b1;
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out !== 8'h00 || bus.pixel_out_ena !== 1'b0 || bus.pixel_out_h !== 8'h00)
            $display("FAIL mid_first_adv: got %h/%h/%b want 00/00/0",
                     bus.pixel_out, bus.pixel_out_h, bus.pixel_out_ena);
        else n_pass++;
        tick(4'd0);
        n_checks++;
        if (bus.pixel_out !== 8'hA5 || bus.pixel_out_ena !== 1'b1 || bus.pixel_out_h !== 8'h7E)
            $display("FAIL mid_second_adv: got %h/%h/%b want a5/7e/1",
                     bus.pixel_out, bus.pixel_out_h, bus.pixel_out_ena);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        reset_n  = 1'b0;
        bus.pc_ena_in = 4'd0;
        set_in(24'h0, 16'h0, 8'h0, 8'h0);
        test_reset();
        test_8bpp();
        test_1bpp();
        test_4bpp_2bpp();
        test_text();
        test_window_hi();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
